// File: rtl/gbsha_fir_mac.sv
// gbsha_fir_mac: time-shared single-MAC FIR with loadable coefs, output shift and saturation; ports: clk, reset, x_in/x_valid/x_ready sample in, coef_we/coef_addr/coef_data coef write, y_out/y_valid/y_sat result
module gbsha_fir_mac #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 4,
  parameter int BW_coef = 4,
  parameter int BW_acc  = 10,
  parameter int BW_out  = 4,
  parameter int SHIFT   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [BW_in-1:0]    x_in,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic                       coef_we,
  input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
  input  logic signed [BW_coef-1:0]  coef_data,
  output logic signed [BW_out-1:0]   y_out,
  output logic                       y_valid,
  output logic                       y_sat
);
  localparam int AW = $clog2(N_TAPS);
  localparam logic signed [BW_acc-1:0] y_max = BW_acc'((1 << (BW_out - 1)) - 1);
  localparam logic signed [BW_acc-1:0] y_min = ~y_max;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state;
  logic signed [BW_in-1:0] x [N_TAPS];
  logic signed [BW_coef-1:0] coef [N_TAPS];
  logic signed [BW_acc-1:0] acc, prod, s;
  logic [AW-1:0] k;
  assign x_ready = state == IDLE;
  always_comb begin
    prod = BW_acc'(coef[k]) * BW_acc'(x[k]);
    s = acc >>> SHIFT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      k <= '0;
      y_out <= '0;
      y_valid <= 1'b0;
      y_sat <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        x[i] <= '0;
        coef[i] <= i == 0 ? BW_coef'(1) : '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we)
            for (int i = 0; i < N_TAPS; i++)
              if (coef_addr == AW'(i)) coef[i] <= coef_data;
          if (x_valid) begin
            x[0] <= x_in;
            for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            k <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k <= k + AW'(1);
          if (k == AW'(N_TAPS - 1)) state <= OUT;
        end
        default: begin
          y_out <= s > y_max ? y_max[BW_out-1:0] : s < y_min ? y_min[BW_out-1:0] : s[BW_out-1:0];
          y_sat <= s > y_max || s < y_min;
          y_valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
